multiword_decoder: RTL and testbench

//  Next-generation swt16 decode stage. Accepts instruction words from fetch via valid/ready.

---
 rtl/multiword_decoder_pkg.sv | 53 +++++
 rtl/multiword_decoder_if.sv | 47 ++++
 rtl/multiword_decoder_instr_length_lookup.sv | 24 ++
 rtl/multiword_decoder.sv | 173 +++++++++++++++++
 tb/tb_multiword_decoder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/multiword_decoder_pkg.sv
// Shared encodings for the swt16 multi-word decode stage: opcodes, function codes, action bits, FSM states.
// Instruction fields: [3:0] opcode, [7:4] rd, [11:8] func2 / rs1, [15:12] rs2 / imm4.
package multiword_decoder_pkg;

    localparam logic [3:0] OPCODE_NOP = 4'h0;
    localparam logic [3:0] OPCODE_U   = 4'h1;
    localparam logic [3:0] OPCODE_SH  = 4'h2;
    localparam logic [3:0] OPCODE_LH  = 4'h3;

    // A U-type LIL targeting r0 is meaningless, so that slot encodes J.
    localparam logic [3:0] FUNC1_J    = 4'h0;
    localparam logic [3:0] FUNC2_LIL  = 4'h0;
    localparam logic [3:0] FUNC2_JAL  = 4'h1;
    localparam logic [3:0] FUNC2_LI   = 4'h3;
    localparam logic [3:0] FUNC2_LIW  = 4'h5;

    localparam int ACT_W              = 7;
    localparam int ACT_IALU_ADD       = 0;
    localparam int ACT_INCR_PC_IS_RES = 1;
    localparam int ACT_JUMP           = 2;
    localparam int ACT_LOAD_DMEM      = 3;
    localparam int ACT_STORE_DMEM     = 4;
    localparam int ACT_WRITE_RES      = 5;
    localparam int ACT_WRITE_SRC2     = 6;

    typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

    typedef enum logic [3:0] {
        K_NOP, K_LIL, K_SH, K_LH, K_J, K_JAL, K_LI, K_LIW, K_ILLEGAL
    } kind_t;

    function automatic kind_t decode_kind(input logic [15:0] w);
        kind_t k;
        k = K_ILLEGAL;
        case (w[3:0])
            OPCODE_NOP: k = K_NOP;
            OPCODE_SH:  k = K_SH;
            OPCODE_LH:  k = K_LH;
            OPCODE_U: begin
                case (w[11:8])
                    FUNC2_LIL: k = (w[7:4] == FUNC1_J) ? K_J : K_LIL;
                    FUNC2_JAL: k = K_JAL;
                    FUNC2_LI:  k = K_LI;
                    FUNC2_LIW: k = K_LIW;
                    default:   ;
                endcase
            end
            default: ;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/multiword_decoder_if.sv
// Fetch / regfile / execute facing signals of the decode stage.
// DECODER_ILLEGAL_TRAP_EN adds the out_illegal flag.
interface multiword_decoder_if #(
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int IALU_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int REG_IDX_WIDTH   = 4
);
    logic                       in_flush;
    logic                       in_stall;
    logic                       in_valid;
    logic                       out_ready;
    logic [PMEM_WORD_WIDTH-1:0] in_instr;
    logic [PC_WIDTH-1:0]        in_pc;
    logic [REG_IDX_WIDTH-1:0]   out_src1_reg_idx;
    logic [REG_IDX_WIDTH-1:0]   out_src2_reg_idx;
    logic [IALU_WORD_WIDTH-1:0] in_src1;
    logic [IALU_WORD_WIDTH-1:0] in_src2;
    logic                       out_valid;
    logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx;
    logic [IALU_WORD_WIDTH-1:0] out_src1;
    logic [IALU_WORD_WIDTH-1:0] out_src2;
    logic [6:0]                 out_act;
    logic [PC_WIDTH-1:0]        out_pc;
`ifdef DECODER_ILLEGAL_TRAP_EN
    logic                       out_illegal;
`endif

    modport master (
`ifdef DECODER_ILLEGAL_TRAP_EN
        input  out_illegal,
`endif
        output in_flush, in_stall, in_valid, in_instr, in_pc, in_src1, in_src2,
        input  out_ready, out_src1_reg_idx, out_src2_reg_idx, out_valid,
               out_res_reg_idx, out_src1, out_src2, out_act, out_pc
    );

    modport slave (
`ifdef DECODER_ILLEGAL_TRAP_EN
        output out_illegal,
`endif
        input  in_flush, in_stall, in_valid, in_instr, in_pc, in_src1, in_src2,
        output out_ready, out_src1_reg_idx, out_src2_reg_idx, out_valid,
               out_res_reg_idx, out_src1, out_src2, out_act, out_pc
    );

endinterface

// File: rtl/multiword_decoder_instr_length_lookup.sv
// Classifies a first instruction word: instruction kind, total word count, illegal flag.
module instr_length_lookup
    import multiword_decoder_pkg::*;
#(
    parameter int MAX_WORDS = 3
) (
    input  logic [15:0]                      word,
    output kind_t                            kind,
    output logic [$clog2(MAX_WORDS+1)-1:0]   len,
    output logic                             illegal
);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    always_comb begin
        kind    = decode_kind(word);
        illegal = (kind == K_ILLEGAL);
        case (kind)
            K_J, K_JAL, K_LI: len = CNT_W'(2);
            K_LIW:            len = CNT_W'(MAX_WORDS);
            default:          len = CNT_W'(1);
        endcase
    end

endmodule

// File: rtl/multiword_decoder.sv
// swt16 decode stage: assembles 1..MAX_WORDS-word instructions and issues one registered bundle each.
// DECODER_ILLEGAL_TRAP_EN: unknown encodings raise sticky out_illegal and block fetch until flush.
module multiword_decoder
    import multiword_decoder_pkg::*;
#(
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int IALU_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int MAX_WORDS       = 3
) (
    input logic              clock,
    input logic              reset,
    multiword_decoder_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_t                     state, state_nxt;
    kind_t                      lk_kind, kind_first, held_kind, kind_i;
    logic [CNT_W-1:0]           lk_len, held_len, cnt;
    logic                       lk_illegal;
    logic [11:0]                held_hi, hi_i;
    logic [PC_WIDTH-1:0]        held_pc, pc_i;
    logic [IALU_WORD_WIDTH-1:0] low_word;
    logic                       first, hold, blocked, accept, last, issue;

    logic [ACT_W-1:0]           act_nxt;
    logic [IALU_WORD_WIDTH-1:0] src1_nxt, src2_nxt;

    instr_length_lookup #(.MAX_WORDS(MAX_WORDS)) u_len (
        .word    (bus.in_instr[15:0]),
        .kind    (lk_kind),
        .len     (lk_len),
        .illegal (lk_illegal)
    );

`ifdef DECODER_ILLEGAL_TRAP_EN
    assign kind_first = lk_kind;
    assign blocked    = bus.out_illegal;
`else
    assign kind_first = lk_illegal ? K_NOP : lk_kind;
    assign blocked    = 1'b0;
`endif

    assign first = (state == ST_IDLE);
    assign hold  = bus.out_valid & bus.in_stall;
    // Fields of the first word come straight from fetch while idle, from the holding register otherwise.
    assign hi_i  = first ? bus.in_instr[15:4] : held_hi;
    assign pc_i  = first ? bus.in_pc : held_pc;
    assign kind_i = first ? kind_first : held_kind;
    assign bus.out_src1_reg_idx = REG_IDX_WIDTH'(hi_i[7:4]);
    assign bus.out_src2_reg_idx = REG_IDX_WIDTH'(hi_i[11:8]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.in_flush)  state_nxt = ST_IDLE;
        else if (accept)   state_nxt = last ? ST_IDLE : ST_COLLECT;
    end

    always_comb begin
        bus.out_ready = !hold && !bus.in_flush && !blocked;
        accept        = bus.in_valid && bus.out_ready;
        last          = first ? (lk_len == CNT_W'(1)) : (cnt + CNT_W'(1) == held_len);
        issue         = accept && last;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            held_len  <= '0;
            held_hi   <= '0;
            held_pc   <= '0;
            held_kind <= K_NOP;
            low_word  <= '0;
        end else if (bus.in_flush) begin
            cnt <= '0;
        end else if (accept) begin
            if (last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (first) begin
                    held_hi   <= bus.in_instr[15:4];
                    held_pc   <= bus.in_pc;
                    held_kind <= kind_first;
                    held_len  <= lk_len;
                end else if (cnt == CNT_W'(1)) begin
                    low_word  <= IALU_WORD_WIDTH'(bus.in_instr);
                end
            end
        end
    end

    always_comb begin
        act_nxt  = '0;
        src1_nxt = '0;
        src2_nxt = '0;
        case (kind_i)
            K_J, K_JAL: begin
                act_nxt[ACT_IALU_ADD] = 1'b1;
                act_nxt[ACT_JUMP]     = 1'b1;
                if (kind_i == K_JAL) begin
                    act_nxt[ACT_INCR_PC_IS_RES] = 1'b1;
                    act_nxt[ACT_WRITE_RES]      = 1'b1;
                end
                src1_nxt = IALU_WORD_WIDTH'(pc_i);
                src2_nxt = IALU_WORD_WIDTH'(bus.in_instr);
            end
            K_LI, K_LIL, K_LIW: begin
                act_nxt[ACT_WRITE_SRC2] = 1'b1;
                act_nxt[ACT_WRITE_RES]  = 1'b1;
                if (kind_i == K_LI)       src2_nxt = IALU_WORD_WIDTH'(bus.in_instr);
                else if (kind_i == K_LIL) src2_nxt = IALU_WORD_WIDTH'(hi_i[11:8]);
                else begin
                    // 32-bit immediate: low half in src2, high half in src1.
                    src2_nxt = low_word;
                    src1_nxt = IALU_WORD_WIDTH'(bus.in_instr);
                end
            end
            K_SH: begin
                act_nxt[ACT_STORE_DMEM] = 1'b1;
                act_nxt[ACT_WRITE_SRC2] = 1'b1;
                src1_nxt = bus.in_src1;
                src2_nxt = bus.in_src2;
            end
            K_LH: begin
                act_nxt[ACT_LOAD_DMEM] = 1'b1;
                act_nxt[ACT_WRITE_RES] = 1'b1;
                src1_nxt = bus.in_src1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.out_valid       <= 1'b0;
            bus.out_act         <= '0;
            bus.out_res_reg_idx <= '0;
            bus.out_src1        <= '0;
            bus.out_src2        <= '0;
            bus.out_pc          <= '0;
        end else if (bus.in_flush) begin
            bus.out_valid <= 1'b0;
            bus.out_act   <= '0;
        end else if (hold) begin
            bus.out_valid <= 1'b1;
        end else if (issue) begin
            bus.out_valid       <= 1'b1;
            bus.out_act         <= act_nxt;
            bus.out_res_reg_idx <= REG_IDX_WIDTH'(hi_i[3:0]);
            bus.out_src1        <= src1_nxt;
            bus.out_src2        <= src2_nxt;
            bus.out_pc          <= pc_i;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef DECODER_ILLEGAL_TRAP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                             bus.out_illegal <= 1'b0;
        else if (bus.in_flush)                 bus.out_illegal <= 1'b0;
        else if (issue && first && lk_illegal) bus.out_illegal <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_multiword_decoder.sv
// Directed bench for multiword_decoder; inputs change on the falling edge, outputs are checked there too.
module tb_multiword_decoder;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    multiword_decoder_if #(.PMEM_WORD_WIDTH(16), .IALU_WORD_WIDTH(16), .PC_WIDTH(12), .REG_IDX_WIDTH(4)) bus ();

    multiword_decoder #(.PMEM_WORD_WIDTH(16), .IALU_WORD_WIDTH(16), .PC_WIDTH(12),
                        .REG_IDX_WIDTH(4), .MAX_WORDS(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(negedge clock);
    endtask

    task automatic word(input logic [15:0] instr, input logic [11:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.out_ready); end
        n_checks++; if (bus.out_act !== 7'h00) begin n_fail++; $display("FAIL reset_act: got %h want 00", bus.out_act); end
        n_checks++; if (bus.out_pc !== 12'h000 || bus.out_src2 !== 16'h0000 || bus.out_res_reg_idx !== 4'h0) begin
            n_fail++; $display("FAIL reset_bundle: got pc %h src2 %h res %h want 0", bus.out_pc, bus.out_src2, bus.out_res_reg_idx); end
        step;
        reset = 1'b0;
    endtask

    task automatic test_lil;
        word(16'h7041, 12'd0);
        step;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL lil_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_act !== 7'h60) begin n_fail++; $display("FAIL lil_act: got %h want 60", bus.out_act); end
        n_checks++; if (bus.out_src2 !== 16'd7) begin n_fail++; $display("FAIL lil_src2: got %h want 0007", bus.out_src2); end
        n_checks++; if (bus.out_res_reg_idx !== 4'd4) begin n_fail++; $display("FAIL lil_res: got %h want 4", bus.out_res_reg_idx); end
        step;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_src2 !== 16'd7) begin
            n_fail++; $display("FAIL lil_drop: got valid %b src2 %h want 0/0007", bus.out_valid, bus.out_src2); end
    endtask

    task automatic test_jump;
        word(16'h0001, 12'd10);
        step;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL j_early: got valid %b want 0", bus.out_valid); end
        word(16'h0020, 12'd11);
        step;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL j_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_src1 !== 16'd10 || bus.out_src2 !== 16'd32) begin
            n_fail++; $display("FAIL j_src: got %h/%h want 000a/0020", bus.out_src1, bus.out_src2); end
        n_checks++; if (bus.out_act !== 7'h05 || bus.out_pc !== 12'd10) begin
            n_fail++; $display("FAIL j_act: got act %h pc %h want 05/00a", bus.out_act, bus.out_pc); end
        step;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL j_single: got valid %b want 0", bus.out_valid); end
    endtask

    // Leaves the SH bundle valid so the stall test can freeze it.
    task automatic test_back_to_back;
        bus.in_src1 = 16'd5;
        bus.in_src2 = 16'd9;
        word(16'h0213, 12'd12);
        #1;
        n_checks++; if (bus.out_src1_reg_idx !== 4'd2) begin n_fail++; $display("FAIL lh_rs1: got %h want 2", bus.out_src1_reg_idx); end
        step;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_act !== 7'h28 || bus.out_src1 !== 16'd5) begin
            n_fail++; $display("FAIL lh_issue: got v %b act %h src1 %h want 1/28/0005", bus.out_valid, bus.out_act, bus.out_src1); end
        word(16'h3202, 12'd13);
        #1;
        n_checks++; if (bus.out_src2_reg_idx !== 4'd3) begin n_fail++; $display("FAIL sh_rs2: got %h want 3", bus.out_src2_reg_idx); end
        step;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_act !== 7'h50) begin
            n_fail++; $display("FAIL sh_issue: got v %b act %h want 1/50", bus.out_valid, bus.out_act); end
        n_checks++; if (bus.out_src1 !== 16'd5 || bus.out_src2 !== 16'd9 || bus.out_pc !== 12'd13) begin
            n_fail++; $display("FAIL sh_src: got %h/%h pc %h want 0005/0009/00d", bus.out_src1, bus.out_src2, bus.out_pc); end
    endtask

    task automatic test_stall;
        bus.in_stall = 1'b1;
        bus.in_src1  = 16'd7;
        bus.in_src2  = 16'd8;
        word(16'h1041, 12'd14);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.out_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.out_ready); end
            step;
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_act !== 7'h50 || bus.out_src1 !== 16'd5 || bus.out_src2 !== 16'd9) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v %b act %h src %h/%h want 1/50/0005/0009",
                                   i, bus.out_valid, bus.out_act, bus.out_src1, bus.out_src2); end
        end
        bus.in_stall = 1'b0;
        #1;
        n_checks++; if (bus.out_ready !== 1'b1 || bus.out_act !== 7'h50) begin
            n_fail++; $display("FAIL stall_release: got ready %b act %h want 1/50", bus.out_ready, bus.out_act); end
        step;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_act !== 7'h60 || bus.out_src2 !== 16'd1 || bus.out_pc !== 12'd14) begin
            n_fail++; $display("FAIL stall_next: got v %b act %h src2 %h pc %h want 1/60/0001/00e",
                               bus.out_valid, bus.out_act, bus.out_src2, bus.out_pc); end
        step;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drop: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush;
        word(16'h0151, 12'd20);
        step;
        bus.in_flush = 1'b1;
        word(16'h0030, 12'd21);
        #1;
        n_checks++; if (bus.out_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", bus.out_ready); end
        step;
        bus.in_flush = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_noissue: got valid %b want 0", bus.out_valid); end
        word(16'h2061, 12'd30);
        step;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_act !== 7'h60 || bus.out_src2 !== 16'd2 ||
                        bus.out_res_reg_idx !== 4'd6 || bus.out_pc !== 12'd30) begin
            n_fail++; $display("FAIL flush_after: got v %b act %h src2 %h res %h pc %h want 1/60/0002/6/01e",
                               bus.out_valid, bus.out_act, bus.out_src2, bus.out_res_reg_idx, bus.out_pc); end
        // Flush must win over a stall on a valid bundle.
        bus.in_stall = 1'b1;
        bus.in_flush = 1'b1;
        step;
        bus.in_stall = 1'b0;
        bus.in_flush = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_act !== 7'h00) begin
            n_fail++; $display("FAIL flush_over_stall: got v %b act %h want 0/00", bus.out_valid, bus.out_act); end
    endtask

    task automatic test_liw;
        word(16'h0521, 12'd40);
        step;
        bus.in_valid = 1'b0;
        step;
        step;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL liw_gap1: got valid %b want 0", bus.out_valid); end
        word(16'hBEEF, 12'd41);
        step;
        bus.in_valid = 1'b0;
        step;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL liw_gap2: got valid %b want 0", bus.out_valid); end
        word(16'h1234, 12'd42);
        step;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_act !== 7'h60 || bus.out_res_reg_idx !== 4'd2 || bus.out_pc !== 12'd40) begin
            n_fail++; $display("FAIL liw_issue: got v %b act %h res %h pc %h want 1/60/2/028",
                               bus.out_valid, bus.out_act, bus.out_res_reg_idx, bus.out_pc); end
        n_checks++; if (bus.out_src2 !== 16'hBEEF || bus.out_src1 !== 16'h1234) begin
            n_fail++; $display("FAIL liw_imm: got src2 %h src1 %h want beef/1234", bus.out_src2, bus.out_src1); end
        step;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL liw_single: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_async_reset;
        word(16'h0151, 12'd50);
        step;
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.out_pc !== 12'd0 || bus.out_ready !== 1'b1 || bus.out_src2 !== 16'd0) begin
            n_fail++; $display("FAIL areset: got pc %h ready %b src2 %h want 000/1/0000", bus.out_pc, bus.out_ready, bus.out_src2); end
        step;
        reset = 1'b0;
        word(16'h0020, 12'd51);
        step;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_act !== 7'h00 || bus.out_src1 !== 16'd0 || bus.out_pc !== 12'd51) begin
            n_fail++; $display("FAIL areset_restart: got v %b act %h src1 %h pc %h want 1/00/0000/033",
                               bus.out_valid, bus.out_act, bus.out_src1, bus.out_pc); end
    endtask

    task automatic test_illegal;
        word(16'h000F, 12'd60);
        step;
        bus.in_valid = 1'b0;
`ifdef DECODER_ILLEGAL_TRAP_EN
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_act !== 7'h00 || bus.out_illegal !== 1'b1 || bus.out_ready !== 1'b0) begin
            n_fail++; $display("FAIL ill_issue: got v %b act %h ill %b ready %b want 1/00/1/0",
                               bus.out_valid, bus.out_act, bus.out_illegal, bus.out_ready); end
        word(16'h7041, 12'd61);
        step;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_illegal !== 1'b1 || bus.out_ready !== 1'b0) begin
            n_fail++; $display("FAIL ill_block: got v %b ill %b ready %b want 0/1/0", bus.out_valid, bus.out_illegal, bus.out_ready); end
        bus.in_flush = 1'b1;
        step;
        bus.in_flush = 1'b0;
        n_checks++; if (bus.out_illegal !== 1'b0 || bus.out_ready !== 1'b1) begin
            n_fail++; $display("FAIL ill_clear: got ill %b ready %b want 0/1", bus.out_illegal, bus.out_ready); end
        word(16'h7041, 12'd62);
        step;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_act !== 7'h60) begin
            n_fail++; $display("FAIL ill_resume: got v %b act %h want 1/60", bus.out_valid, bus.out_act); end
`else
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_act !== 7'h00 || bus.out_ready !== 1'b1 || bus.out_src2 !== 16'd0) begin
            n_fail++; $display("FAIL unk_nop: got v %b act %h ready %b src2 %h want 1/00/1/0000",
                               bus.out_valid, bus.out_act, bus.out_ready, bus.out_src2); end
`endif
        step;
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_flush = 1'b0;
        bus.in_stall = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_pc    = '0;
        bus.in_src1  = '0;
        bus.in_src2  = '0;
        test_reset;
        test_lil;
        test_jump;
        test_back_to_back;
        test_stall;
        test_flush;
        test_liw;
        test_async_reset;
        test_illegal;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
